// File: rtl/tlul_pkg.sv
// Minimal TL-UL type set used by the fuzz host: channel structs, opcodes and the A-user default.
// Pure declarations, no latency or flow control of its own.
// Widths follow the usual 32-bit TL-UL profile with 8-bit source IDs.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef logic [7:0] tl_a_user_t;
    localparam tl_a_user_t TL_A_USER_DEFAULT = 8'h00;

    typedef struct packed {
        logic               a_valid;
        tl_a_op_e           a_opcode;
        logic [2:0]         a_param;
        logic [TL_SZW-1:0]  a_size;
        logic [TL_AIW-1:0]  a_source;
        logic [TL_AW-1:0]   a_address;
        logic [TL_DBW-1:0]  a_mask;
        logic [TL_DW-1:0]   a_data;
        tl_a_user_t         a_user;
        logic               d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic               d_valid;
        tl_d_op_e           d_opcode;
        logic [2:0]         d_param;
        logic [TL_SZW-1:0]  d_size;
        logic [TL_AIW-1:0]  d_source;
        logic [TL_DIW-1:0]  d_sink;
        logic [TL_DW-1:0]   d_data;
        logic               d_error;
        logic               a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_fuzz_host_if.sv
// TL-UL link between the fuzz host (master) and the device under test (slave).
// Wires only: no latency; a_ready/d_ready carry the backpressure.
// h2d is the host request channel, d2h the device response channel.
interface tlul_fuzz_host_if;
    import tlul_pkg::*;

    tl_h2d_t h2d;
    tl_d2h_t d2h;

    modport master (output h2d, input d2h);
    modport slave  (input h2d, output d2h);

endinterface

// File: rtl/tlul_fuzz_host.sv
// Fuzzer instruction stream -> single-outstanding TL-UL host; optional TLUL_FUZZ_ADDR_MASK_EN clamps/aligns a_address.
// Latency: accept -> a_valid next cycle; d_valid -> rdata_valid_o/err_o next cycle; timeout TimeoutCycles after A-handshake.
// Backpressure: instr_ready_o only in IDLE; a_valid held until a_ready; d_ready always 1 (stray responses dropped as errors).
module tlul_fuzz_host
    import tlul_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned WaitW         = 16,
    parameter int unsigned SrcW          = 8,
    parameter logic [31:0] AddrMask      = 32'h0000_0FFF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [65:0]      instr_i,
    tlul_fuzz_host_if.master tl,
    output logic             rdata_valid_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam int unsigned   TW        = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0] TimerLast = TW'(TimeoutCycles - 1);
    localparam logic [1:0]    OP_WAIT   = 2'b00;
    localparam logic [1:0]    OP_READ   = 2'b01;
    localparam logic [1:0]    OP_WRITE  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_RSP} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WaitW-1:0]   r_wait_cnt;
    logic [TW-1:0]      r_timer;
    logic [SrcW-1:0]    r_src_id;
    logic               r_is_read;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic [31:0]        r_rdata;
    logic               r_rdata_vld;
    logic               r_err;

    logic [1:0]         w_op;
    logic [31:0]        w_addr;
    logic [31:0]        w_data;
    logic [WaitW-1:0]   w_wait_n;
    logic               w_accept;
    logic               w_launch;
    logic               w_rsp;
    logic               w_timeout;
    logic               w_stray;
    logic               w_rsp_bad;
    logic [TL_AIW-1:0]  w_src_ext;
    logic               w_unused;

    assign w_op     = instr_i[65:64];
    assign w_data   = instr_i[31:0];
    assign w_wait_n = w_data[WaitW-1:0];

`ifdef TLUL_FUZZ_ADDR_MASK_EN
    assign w_addr = instr_i[63:32] & AddrMask & ~32'h3;
`else
    assign w_addr = instr_i[63:32];
`endif

    assign w_src_ext = TL_AIW'(r_src_id);
    assign w_stray   = tl.d2h.d_valid && (r_state != S_RSP);
    assign w_rsp_bad = tl.d2h.d_error || (tl.d2h.d_source != w_src_ext);
    assign w_unused  = ^{tl.d2h.d_opcode, tl.d2h.d_param, tl.d2h.d_size, tl.d2h.d_sink, AddrMask};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_launch    = 1'b0;
        w_rsp       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (instr_valid_i) begin
                    w_accept = 1'b1;
                    if (w_op == OP_WAIT && w_wait_n != '0) begin
                        w_state_nxt = S_WAIT;
                    end
                    if (w_op == OP_READ || w_op == OP_WRITE) begin
                        w_launch    = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == WaitW'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                if (tl.d2h.a_ready) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                // A response landing on the timeout cycle takes priority over the timeout.
                if (tl.d2h.d_valid) begin
                    w_rsp       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer >= TimerLast) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt  <= '0;
            r_timer     <= '0;
            r_src_id    <= '0;
            r_is_read   <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rdata     <= '0;
            r_rdata_vld <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err       <= w_stray || w_timeout || (w_rsp && w_rsp_bad);
            r_rdata_vld <= w_rsp && !w_rsp_bad && r_is_read;
            if (w_rsp && !w_rsp_bad && r_is_read) begin
                r_rdata <= tl.d2h.d_data;
            end
            if (w_accept && w_op == OP_WAIT) begin
                r_wait_cnt <= w_wait_n;
            end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - WaitW'(1);
            end
            if (w_launch) begin
                r_is_read <= (w_op == OP_READ);
                r_addr    <= w_addr;
                r_data    <= (w_op == OP_WRITE) ? w_data : 32'h0;
            end
            if (r_state == S_REQ) begin
                r_timer <= '0;
            end else if (r_state == S_RSP && r_timer != '1) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_rsp || w_timeout) begin
                r_src_id <= r_src_id + SrcW'(1);
            end
        end
    end

    assign instr_ready_o = (r_state == S_IDLE);
    assign busy_o        = (r_state != S_IDLE);
    assign rdata_valid_o = r_rdata_vld;
    assign rdata_o       = r_rdata;
    assign err_o         = r_err;

    assign tl.h2d = '{
        a_valid:   (r_state == S_REQ),
        a_opcode:  (r_is_read ? Get : PutFullData),
        a_param:   3'h0,
        a_size:    2'd2,
        a_source:  w_src_ext,
        a_address: r_addr,
        a_mask:    4'hF,
        a_data:    r_data,
        a_user:    TL_A_USER_DEFAULT,
        d_ready:   1'b1
    };

endmodule
